// File: rtl/data_mem_handler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_handler_if: decode-side controls and data-bus signals    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
interface data_mem_handler_if;
  logic        read_mem;
  logic        write_mem;
  logic        load_byte;
  logic        store_byte;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] mem_data_out;
  logic        freeze;
  logic        misaligned;
  logic        bus_error;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  read_mem, write_mem, load_byte, store_byte, alu_result, store_data,
    input  bus_rdata, bus_ack,
    output mem_data_out, freeze, misaligned, bus_error,
    output bus_addr, bus_wdata, bus_sel, bus_read, bus_write
  );

  modport slave (
    output read_mem, write_mem, load_byte, store_byte, alu_result, store_data,
    output bus_rdata, bus_ack,
    input  mem_data_out, freeze, misaligned, bus_error,
    input  bus_addr, bus_wdata, bus_sel, bus_read, bus_write
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_handler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_handler: one bus transaction per load/store with stall,  |
// | byte-lane steering, lb sign extension, misalign/timeout detection |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module data_mem_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  data_mem_handler_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter value seen in the last REQ cycle before giving up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic        misaligned_q, misaligned_d;
  logic [1:0]  lane_q, lane_d;
  logic        byte_q, byte_d;

  logic        req;
  logic        is_write;
  logic        is_byte;
  logic [1:0]  lane;
  logic        misalign;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [31:0] rdata_shifted;
  logic [7:0]  rd_byte;
  logic [31:0] load_result;
  logic        freeze;
  logic        bus_error;

  // Write wins when decode raises both controls, so the byte flag follows it.
  assign req       = bus.read_mem | bus.write_mem;
  assign is_write  = bus.write_mem;
  assign is_byte   = is_write ? bus.store_byte : bus.load_byte;
  assign lane      = bus.alu_result[1:0];
  assign misalign  = req && !is_byte && (lane != 2'b00);
  assign req_sel   = is_byte ? (4'b0001 << lane) : 4'b1111;
  assign req_wdata = is_byte ? {4{bus.store_data[7:0]}} : bus.store_data;

  assign rdata_shifted = bus.bus_rdata >> {lane_q, 3'b000};
  assign rd_byte       = rdata_shifted[7:0];
  assign load_result   = byte_q ? {{24{rd_byte[7]}}, rd_byte} : bus.bus_rdata;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_data_out_d = mem_data_out_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_sel_d      = bus_sel_q;
    bus_read_d     = bus_read_q;
    bus_write_d    = bus_write_q;
    lane_d         = lane_q;
    byte_d         = byte_q;
    misaligned_d   = 1'b0;
    freeze         = 1'b0;
    bus_error      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (misalign) begin
            misaligned_d = 1'b1;
          end else begin
            freeze      = 1'b1;
            state_d     = ST_REQ;
            cnt_d       = 8'd0;
            bus_addr_d  = {bus.alu_result[31:2], 2'b00};
            bus_wdata_d = req_wdata;
            bus_sel_d   = req_sel;
            bus_read_d  = !is_write;
            bus_write_d = is_write;
            lane_d      = lane;
            byte_d      = is_byte;
          end
        end
      end

      ST_REQ: begin
        freeze = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (bus.bus_ack) begin
          if (bus_read_q) begin
            mem_data_out_d = load_result;
          end
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          bus_error   = 1'b1;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      mem_data_out_q <= 32'd0;
      bus_addr_q     <= 32'd0;
      bus_wdata_q    <= 32'd0;
      bus_sel_q      <= 4'd0;
      bus_read_q     <= 1'b0;
      bus_write_q    <= 1'b0;
      misaligned_q   <= 1'b0;
      lane_q         <= 2'd0;
      byte_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_data_out_q <= mem_data_out_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_sel_q      <= bus_sel_d;
      bus_read_q     <= bus_read_d;
      bus_write_q    <= bus_write_d;
      misaligned_q   <= misaligned_d;
      lane_q         <= lane_d;
      byte_q         <= byte_d;
    end
  end

  assign bus.mem_data_out = mem_data_out_q;
  assign bus.freeze       = freeze;
  assign bus.misaligned   = misaligned_q;
  assign bus.bus_error    = bus_error;
  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_wdata    = bus_wdata_q;
  assign bus.bus_sel      = bus_sel_q;
  assign bus.bus_read     = bus_read_q;
  assign bus.bus_write    = bus_write_q;

endmodule
`default_nettype wire
